// File: rtl/odu_osu_slot_scheduler_if.sv
// Bundle between the OSU sources / ODU framer and the slot scheduler.
//   enable      : run enable
//   cfg_src_en  : per-source eligibility mask
//   src_valid   : per-source word available
//   src_data    : flat source words, source i at [i*DATA_W +: DATA_W]
//   src_ready   : one-hot grant back to the sources (combinational)
//   slot_req    : framer asks for one payload word
//   out_*       : registered scheduled beat, row/frame markers, stuff counter
// master = source/framer side, slave = scheduler.
interface odu_osu_slot_scheduler_if #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int DATA_W  = 384
);
  logic                      enable;
  logic [NUM_SRC-1:0]        cfg_src_en;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      slot_req;
  logic [DATA_W-1:0]         out_data;
  logic                      out_valid;
  logic                      out_stuff;
  logic [SRC_W-1:0]          out_src_id;
  logic                      row_start;
  logic                      frame_start;
  logic [15:0]               stuff_cnt;

  modport master (
    output enable, cfg_src_en, src_valid, src_data, slot_req,
    input  src_ready, out_data, out_valid, out_stuff, out_src_id,
           row_start, frame_start, stuff_cnt
  );

  modport slave (
    input  enable, cfg_src_en, src_valid, src_data, slot_req,
    output src_ready, out_data, out_valid, out_stuff, out_src_id,
           row_start, frame_start, stuff_cnt
  );
endinterface

// File: rtl/odu_osu_slot_scheduler.sv
// Round-robin scheduler sharing ODU payload slots between NUM_SRC OSU sources.
// On each accepted slot_req the first eligible source at or above rr_ptr is
// granted (src_ready, same cycle) and its word is registered to out_data one
// cycle later; with nothing eligible a stuff word is emitted instead. Slot/row
// position is tracked so row_start/frame_start mark the first beat of each
// row/frame.
// Ports: clk, rst_n (async, active low), bus (slave modport of
// odu_osu_slot_scheduler_if).
module odu_osu_slot_scheduler #(
  parameter int          NUM_SRC        = 4,
  parameter int          SRC_W          = 2,
  parameter int          DATA_W         = 384,
  parameter int          SLOTS_PER_ROW  = 80,
  parameter int          ROWS_PER_FRAME = 4,
  parameter logic [7:0]  STUFF_BYTE     = 8'h99
) (
  input  logic                     clk,
  input  logic                     rst_n,
  odu_osu_slot_scheduler_if.slave  bus
);

  localparam int SLOT_W = (SLOTS_PER_ROW  > 1) ? $clog2(SLOTS_PER_ROW)  : 1;
  localparam int ROW_W  = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOTS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS_PER_FRAME - 1);
  localparam logic [DATA_W-1:0] STUFF_WORD = {(DATA_W/8){STUFF_BYTE}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
  logic [15:0]         stuff_cnt_q, stuff_cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_stuff_q, out_stuff_d;
  logic [SRC_W-1:0]    out_src_id_q, out_src_id_d;
  logic                row_start_q, row_start_d;
  logic                frame_start_q, frame_start_d;

  logic                run, accept;
  logic [NUM_SRC-1:0]  elig, grant_oh;
  logic [SRC_W-1:0]    grant_id, idx;
  logic                grant_vld;
  logic [DATA_W-1:0]   grant_data;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.enable)  state_d = S_RUN;
      S_RUN:   if (!bus.enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; a falling enable blocks the request in the same cycle
  always_comb begin
    run           = (state_q == S_RUN);
    accept        = run & bus.enable & bus.slot_req;
    bus.src_ready = accept ? grant_oh : '0;
  end

  // Rotating search: SRC_W-bit add wraps modulo NUM_SRC (power of two).
  always_comb begin
    elig      = bus.src_valid & bus.cfg_src_en;
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    idx       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_ptr_q + SRC_W'(k);
      if (!grant_vld && elig[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
    grant_oh[grant_id] = grant_vld;
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (grant_oh[i]) grant_data = bus.src_data[i*DATA_W +: DATA_W];
  end

  // Datapath next values. Leaving RUN wipes everything so the next run
  // restarts at slot 0 of row 0 with a fresh pointer and stuff count.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    slot_cnt_d    = slot_cnt_q;
    row_cnt_d     = row_cnt_q;
    stuff_cnt_d   = stuff_cnt_q;
    out_data_d    = out_data_q;
    out_stuff_d   = out_stuff_q;
    out_src_id_d  = out_src_id_q;
    out_valid_d   = 1'b0;
    row_start_d   = 1'b0;
    frame_start_d = 1'b0;
    if (run && !bus.enable) begin
      rr_ptr_d     = '0;
      slot_cnt_d   = '0;
      row_cnt_d    = '0;
      stuff_cnt_d  = '0;
      out_data_d   = '0;
      out_stuff_d  = 1'b0;
      out_src_id_d = '0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      row_start_d   = (slot_cnt_q == '0);
      frame_start_d = (slot_cnt_q == '0) && (row_cnt_q == '0);
      if (slot_cnt_q == SLOT_LAST) begin
        slot_cnt_d = '0;
        row_cnt_d  = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
      if (grant_vld) begin
        out_data_d   = grant_data;
        out_stuff_d  = 1'b0;
        out_src_id_d = grant_id;
        rr_ptr_d     = grant_id + 1'b1;
      end else begin
        out_data_d   = STUFF_WORD;
        out_stuff_d  = 1'b1;
        out_src_id_d = '0;
        if (stuff_cnt_q != 16'hFFFF) stuff_cnt_d = stuff_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      slot_cnt_q    <= '0;
      row_cnt_q     <= '0;
      stuff_cnt_q   <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_stuff_q   <= 1'b0;
      out_src_id_q  <= '0;
      row_start_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      slot_cnt_q    <= slot_cnt_d;
      row_cnt_q     <= row_cnt_d;
      stuff_cnt_q   <= stuff_cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_stuff_q   <= out_stuff_d;
      out_src_id_q  <= out_src_id_d;
      row_start_q   <= row_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_stuff   = out_stuff_q;
  assign bus.out_src_id  = out_src_id_q;
  assign bus.row_start   = row_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.stuff_cnt   = stuff_cnt_q;

endmodule

// File: tb/tb_odu_osu_slot_scheduler.sv
module tb_odu_osu_slot_scheduler;
  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 2;
  localparam int DATA_W  = 384;
  localparam int SLOTS   = 80;
  localparam int ROWS    = 4;
  localparam logic [DATA_W-1:0] STUFF = {48{8'h99}};

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              stuff;
    logic [SRC_W-1:0]  id;
    logic              rs;
    logic              fs;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  odu_osu_slot_scheduler_if #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .DATA_W(DATA_W)) bus();

  odu_osu_slot_scheduler #(
    .NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .DATA_W(DATA_W),
    .SLOTS_PER_ROW(SLOTS), .ROWS_PER_FRAME(ROWS), .STUFF_BYTE(8'h99)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  bit             m_run;
  int             m_rr, m_slot, m_row, m_stuff;
  beat_t          sbq[$];
  logic [NUM_SRC-1:0] last_ready;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_rr = 0; m_slot = 0; m_row = 0; m_stuff = 0;
  endtask

  // One clock: evaluate the request against the model, check the grant,
  // then check the registered beat after the edge.
  task automatic tick();
    beat_t e;
    bit found;
    int g;
    logic [NUM_SRC-1:0] exp_rdy;
    for (int i = 0; i < NUM_SRC; i++)
      for (int w = 0; w < DATA_W/32; w++)
        bus.src_data[i*DATA_W + w*32 +: 32] = $urandom;
    #1;
    exp_rdy = '0;
    if (m_run && bus.enable && bus.slot_req) begin
      found = 0; g = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
        int i;
        i = (m_rr + k) % NUM_SRC;
        if (!found && bus.src_valid[i] && bus.cfg_src_en[i]) begin found = 1; g = i; end
      end
      e.rs = (m_slot == 0);
      e.fs = (m_slot == 0) && (m_row == 0);
      if (found) begin
        e.data = bus.src_data[g*DATA_W +: DATA_W];
        e.stuff = 1'b0; e.id = SRC_W'(g);
        exp_rdy[g] = 1'b1;
        m_rr = (g + 1) % NUM_SRC;
      end else begin
        e.data = STUFF; e.stuff = 1'b1; e.id = '0;
        if (m_stuff < 65535) m_stuff++;
      end
      if (m_slot == SLOTS-1) begin m_slot = 0; m_row = (m_row + 1) % ROWS; end
      else m_slot++;
      sbq.push_back(e);
    end
    last_ready = bus.src_ready;
    chk("src_ready", bus.src_ready, exp_rdy);
    if (m_run && !bus.enable) begin m_run = 0; model_clear(); end
    else if (!m_run && bus.enable) m_run = 1;
    @(posedge clk); #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("out_valid", bus.out_valid, 1'b1);
      chk("out_data", bus.out_data, e.data);
      chk("out_stuff", bus.out_stuff, e.stuff);
      chk("out_src_id", bus.out_src_id, e.id);
      chk("row_start", bus.row_start, e.rs);
      chk("frame_start", bus.frame_start, e.fs);
    end else begin
      chk("out_valid_idle", bus.out_valid, 1'b0);
      chk("row_start_idle", bus.row_start, 1'b0);
      chk("frame_start_idle", bus.frame_start, 1'b0);
      if (!m_run) begin
        chk("out_data_idle", bus.out_data, '0);
        chk("out_stuff_idle", bus.out_stuff, 1'b0);
        chk("out_src_id_idle", bus.out_src_id, '0);
      end
    end
    chk("stuff_cnt", bus.stuff_cnt, m_stuff);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_data"}, bus.out_data, '0);
    chk({tag, "_stuff"}, bus.out_stuff, 1'b0);
    chk({tag, "_id"}, bus.out_src_id, '0);
    chk({tag, "_rs"}, bus.row_start, 1'b0);
    chk({tag, "_fs"}, bus.frame_start, 1'b0);
    chk({tag, "_scnt"}, bus.stuff_cnt, '0);
    chk({tag, "_ready"}, bus.src_ready, '0);
  endtask

  task automatic restart();
    bus.enable = 1'b0; bus.slot_req = 1'b0;
    tick();
    bus.enable = 1'b1;
    tick();
  endtask

  int rs_cnt, fs_cnt;

  initial begin
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.slot_req = 1'b0;
    bus.cfg_src_en = '0; bus.src_valid = '0; bus.src_data = '0;
    m_run = 0; model_clear();
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // all sources valid: strict rotation 0,1,2,3,...
    bus.enable = 1'b1;
    tick();
    bus.cfg_src_en = 4'b1111; bus.src_valid = 4'b1111; bus.slot_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_onehot", last_ready, 4'b0001 << (k % 4));
      chk("rr_id", bus.out_src_id, k % 4);
    end

    // only source 2 valid, then nobody -> stuff
    bus.src_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("src2_id", bus.out_src_id, 2);
      chk("src2_stuff", bus.out_stuff, 1'b0);
    end
    bus.src_valid = 4'b0000;
    tick();
    chk("stuff_data", bus.out_data, STUFF);
    chk("stuff_flag", bus.out_stuff, 1'b1);
    chk("stuff_cnt1", bus.stuff_cnt, 16'd1);

    // enable falls with slot_req high: no grant, state cleared
    bus.enable = 1'b0; bus.src_valid = 4'b1111;
    tick();
    chk("en_fall_ready", last_ready, '0);
    tick();
    chk("en_fall_scnt", bus.stuff_cnt, 16'd0);

    // masked sources: 1,3,1,3
    bus.enable = 1'b1; bus.slot_req = 1'b0;
    tick();
    bus.cfg_src_en = 4'b1010; bus.slot_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mask_id", bus.out_src_id, (k % 2) ? 3 : 1);
      chk("mask_no02", last_ready & 4'b0101, '0);
    end

    // one full frame plus one beat
    restart();
    bus.cfg_src_en = 4'b1111; bus.slot_req = 1'b1;
    rs_cnt = 0; fs_cnt = 0;
    for (int b = 1; b <= 321; b++) begin
      tick();
      if (bus.row_start)   rs_cnt++;
      if (bus.frame_start) fs_cnt++;
      if (b == 81 || b == 161 || b == 241) chk("row_start_pos", bus.row_start, 1'b1);
      if (b == 321) chk("frame_start_321", bus.frame_start, 1'b1);
    end
    chk("row_start_cnt", rs_cnt, 5);
    chk("frame_start_cnt", fs_cnt, 2);

    // gapped requests, drop enable at slot 40, restart at frame start
    restart();
    for (int k = 0; k < 80; k++) begin
      bus.slot_req = (k % 2 == 0);
      bus.src_valid = 4'($urandom);
      tick();
    end
    bus.slot_req = 1'b1; bus.enable = 1'b0;
    tick();
    tick();
    bus.enable = 1'b1; bus.slot_req = 1'b0;
    tick();
    bus.slot_req = 1'b1; bus.src_valid = 4'b1111;
    tick();
    chk("restart_fs", bus.frame_start, 1'b1);
    chk("restart_rs", bus.row_start, 1'b1);
    tick();
    chk("restart_second_rs", bus.row_start, 1'b0);

    // asynchronous reset while requesting
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    sbq.delete(); m_run = 0; model_clear();
    bus.enable = 1'b0; bus.slot_req = 1'b0;
    #10;
    rst_n = 1'b1;
    bus.enable = 1'b1;
    tick();
    bus.slot_req = 1'b1;
    tick();
    chk("post_rst_fs", bus.frame_start, 1'b1);
    chk("post_rst_rs", bus.row_start, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/odu_osu_slot_scheduler.md
Name: odu_osu_slot_scheduler

Overview:
- Round-robin scheduler sharing the ODU payload slots between NUM_SRC OSU packet sources.
- Sits between the OSU generators and the ODU framer.
- Each time the framer requests a payload word, the block grants one eligible source, or inserts a byte-stuff word when no source is eligible.
- Tracks slot/row position in the ODU frame and flags row and frame starts.

Parameters:
- NUM_SRC, 4, number of OSU sources (power of 2, 2..8)
- SRC_W, 2, source-id width, equal to log2(NUM_SRC)
- DATA_W, 384, payload word width in bits
- SLOTS_PER_ROW, 80, payload words per ODU row
- ROWS_PER_FRAME, 4, rows per ODU frame
- STUFF_BYTE, 8'h99, byte replicated across DATA_W for stuff words

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run enable; low forces IDLE
- cfg_src_en  in  NUM_SRC  per-source eligibility mask
- src_valid  in  NUM_SRC  per-source word available
- src_data  in  NUM_SRC*DATA_W  source words; source i occupies bits [i*DATA_W +: DATA_W]
- src_ready  out  NUM_SRC  one-hot grant, combinational
- slot_req  in  1  framer requests one payload word this cycle
- out_data  out  DATA_W  scheduled word
- out_valid  out  1  out_data valid, one cycle per accepted slot_req
- out_stuff  out  1  out_data is a stuff word
- out_src_id  out  SRC_W  granted source (0 when out_stuff)
- row_start  out  1  beat is slot 0 of a row
- frame_start  out  1  beat is slot 0 of row 0
- stuff_cnt  out  16  saturating count of stuff words since reset/IDLE

Behaviour:
- Reset (rst_n low, asynchronous), all outputs 0:
  - state=IDLE, rr_ptr=0, slot_cnt=0, row_cnt=0.
- States:
  - IDLE: outputs held 0, src_ready=0. Moves to RUN on enable=1 in the next cycle.
  - RUN: serves slot_req. enable=0 returns to IDLE next cycle; counters, rr_ptr and stuff_cnt clear and out_valid drops. The in-flight beat already registered is still presented that one cycle. No partial row resumes.
- Eligibility: eligible[i] = src_valid[i] & cfg_src_en[i].
- Grant, in RUN with slot_req=1:
  - Search from rr_ptr upward, modulo NUM_SRC; the first eligible source g wins.
  - src_ready[g]=1 in the same cycle; the transfer occurs in that cycle.
  - rr_ptr becomes (g+1) mod NUM_SRC.
  - src_ready is all-zero whenever slot_req=0 or state is not RUN.
- No eligible source: stuff beat. out_data = STUFF_BYTE replicated, out_stuff=1, out_src_id=0, rr_ptr unchanged, stuff_cnt+1 saturating at 16'hFFFF.
- Latency: 1 cycle. Output regs load on each accepted slot_req. out_valid=1 the cycle after acceptance, else 0. out_data/out_src_id/out_stuff hold their last values when out_valid=0.
- Position counters:
  - Each accepted slot_req (grant or stuff) advances slot_cnt.
  - slot_cnt wraps at SLOTS_PER_ROW-1 to 0 and increments row_cnt.
  - row_cnt wraps at ROWS_PER_FRAME-1 to 0.
  - row_start=1 on the output beat whose pre-increment slot_cnt was 0.
  - frame_start=1 when that beat is also row_cnt=0.
  - Both are registered alongside out_valid and are 0 when out_valid=0.
- Simultaneous events:
  - cfg_src_en change takes effect on the same cycle's eligibility.
  - slot_req with enable falling: enable wins; no grant, no beat.
  - A source deasserting src_valid after losing needs no state.

Test Plan:
- Reset mid-RUN (rst_n pulsed low asynchronously while slot_req=1) -> all outputs 0 immediately. After release plus enable, first beat has frame_start=1, row_start=1.
- All 4 sources valid, slot_req held 1 for 8 cycles -> out_src_id sequence 0,1,2,3,0,1,2,3. src_ready one-hot 0001,0010,0100,1000 repeating, out_valid 1 each cycle from cycle 2.
- Only source 2 valid, cfg_src_en=4'b1111, slot_req=1 for 3 cycles -> out_src_id 2,2,2, out_stuff=0. Then clear src_valid -> out_data all bytes 8'h99, out_stuff=1, stuff_cnt=1.
- cfg_src_en=4'b1010, all sources valid -> grants alternate 1,3,1,3. Sources 0 and 2 never see src_ready.
- 320 consecutive accepted slot_reqs -> row_start on beats 1, 81, 161, 241; frame_start only on beat 1; beat 321 has frame_start=1.
- slot_req gapped (1 then 0 alternating) -> out_valid alternates, slot_cnt advances only on accepted requests. enable dropped at slot 40 -> next enable restarts at slot 0 with frame_start=1.
